// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a four-digit 7-segment display with
// per-frame input shadowing, guard blanking between digits and frame-counted blink.
module seg_scan_driver #(
    parameter int CLK_DIV      = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [27:0] seg_in,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  cathode,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          phase_q, phase_d;
    logic [27:0]   seg_sh_q, seg_sh_d;
    logic [3:0]    blink_sh_q, blink_sh_d;
    logic [3:0]    dp_sh_q, dp_sh_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_done_q, frame_done_d;

    logic          pre_wrap;
    logic          frame_start;
    logic          frame_end;
    logic          in_guard;
    logic          blank;
    logic [1:0]    slot_k;
    logic [6:0]    digit;

    always_comb begin
        pre_wrap    = (pre_q == PRE_MAX);
        frame_start = (pre_q == '0) && (idx_q == 2'd0);
        frame_end   = pre_wrap && (idx_q == 2'd3);

        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d = pre_wrap ? idx_q + 2'd1 : idx_q;

        // Phase flips on the last cycle of a frame so the output timeline
        // sees the new phase exactly on the frame_done cycle.
        fc_d    = fc_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (fc_q == FC_MAX) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        seg_sh_d   = seg_sh_q;
        blink_sh_d = blink_sh_q;
        dp_sh_d    = dp_sh_q;
        if (frame_start) begin
            seg_sh_d   = seg_in;
            blink_sh_d = blink_mask;
            dp_sh_d    = dp_mask;
        end
    end

    // Output stage reads the next-shadow values so the first slot of a frame
    // already shows the snapshot taken on that same edge.
    always_comb begin
        slot_k   = 2'd3 - idx_q;
        in_guard = (int'(pre_q) < GUARD);
        blank    = phase_q && blink_sh_d[slot_k];
        case (idx_q)
            2'd0:    digit = seg_sh_d[27:21];
            2'd1:    digit = seg_sh_d[20:14];
            2'd2:    digit = seg_sh_d[13:7];
            default: digit = seg_sh_d[6:0];
        endcase

        an_d         = 4'hF;
        cathode_d    = 7'h7F;
        dp_n_d       = 1'b1;
        frame_done_d = frame_start;
        if (enable && !in_guard) begin
            an_d = ~(4'b1000 >> idx_q);
            if (!blank) begin
                cathode_d = ~digit;
                dp_n_d    = ~dp_sh_d[slot_k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q        <= '0;
            idx_q        <= 2'd0;
            fc_q         <= '0;
            phase_q      <= 1'b0;
            seg_sh_q     <= '0;
            blink_sh_q   <= '0;
            dp_sh_q      <= '0;
            an_q         <= 4'hF;
            cathode_q    <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            fc_q         <= fc_d;
            phase_q      <= phase_d;
            seg_sh_q     <= seg_sh_d;
            blink_sh_q   <= blink_sh_d;
            dp_sh_q      <= dp_sh_d;
            an_q         <= an_d;
            cathode_q    <= cathode_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign cathode    = cathode_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Frame-table bench for seg_scan_driver: every cycle of each frame is predicted
// from the table's expected digit patterns and checked through a scoreboard queue.
module tb_seg_scan_driver;

    localparam int CLK_DIV      = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * CLK_DIV;

    localparam logic [27:0] S1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] S0000 = {4{7'h3F}};
    localparam logic [27:0] C1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] C0000 = {4{7'h40}};

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [27:0] seg_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  cathode;
    logic        dp_n;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .CLK_DIV     (CLK_DIV),
        .GUARD       (GUARD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .seg_in    (seg_in),
        .blink_mask(blink_mask),
        .dp_mask   (dp_mask),
        .an        (an),
        .cathode   (cathode),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    // seg1 replaces seg0 from cycle 'mid'; enable is low for cycles [off_from, off_to).
    // Expected fields use bit 3 / [27:21] for the leftmost digit (slot 0).
    typedef struct {
        logic [27:0] seg0;
        logic [27:0] seg1;
        int          mid;
        logic [3:0]  blink;
        logic [3:0]  dp;
        int          off_from;
        int          off_to;
        logic [27:0] exp_cath;
        logic [3:0]  exp_blank;
        logic [3:0]  exp_dpn;
    } frame_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cath;
        logic       dpn;
        logic       fd;
    } obs_t;

    frame_t tbl[12];
    obs_t   sb_q[$];
    int     total = 0;
    int     bad   = 0;

    function automatic frame_t mk(input logic [27:0] s0, input logic [27:0] s1, input int mid,
                                  input logic [3:0] bl, input logic [3:0] dp,
                                  input int off_from, input int off_to,
                                  input logic [27:0] ec, input logic [3:0] eb,
                                  input logic [3:0] ed);
        frame_t r;
        r.seg0 = s0; r.seg1 = s1; r.mid = mid; r.blink = bl; r.dp = dp;
        r.off_from = off_from; r.off_to = off_to;
        r.exp_cath = ec; r.exp_blank = eb; r.exp_dpn = ed;
        return r;
    endfunction

    function automatic obs_t expect_cycle(input frame_t r, input int c, input logic en);
        obs_t e;
        int   slot = c / CLK_DIV;
        int   pre  = c % CLK_DIV;
        int   k    = 3 - slot;
        e.an   = 4'hF;
        e.cath = 7'h7F;
        e.dpn  = 1'b1;
        e.fd   = (c == 0);
        if (en && pre >= GUARD) begin
            e.an[k] = 1'b0;
            if (!r.exp_blank[k]) begin
                e.cath = r.exp_cath[k*7 +: 7];
                e.dpn  = r.exp_dpn[k];
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        total++;
        if ({an, cathode, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL %s: got an=%b cathode=%h dp_n=%b frame_done=%b, want an=1111 cathode=7f dp_n=1 frame_done=0",
                     tag, an, cathode, dp_n, frame_done);
        end
    endtask

    task automatic run_frame(input int fi, input int last);
        frame_t r;
        obs_t   e;
        obs_t   got;
        r = tbl[fi];
        for (int c = 0; c <= last; c++) begin
            seg_in     = (c >= r.mid) ? r.seg1 : r.seg0;
            blink_mask = r.blink;
            dp_mask    = r.dp;
            enable     = !(c >= r.off_from && c < r.off_to);
            sb_q.push_back(expect_cycle(r, c, enable));
            step();
            got = {an, cathode, dp_n, frame_done};
            e   = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scan f%0d c%0d: got an=%b cath=%h dp_n=%b fd=%b, want an=%b cath=%h dp_n=%b fd=%b",
                         fi, c, got.an, got.cath, got.dpn, got.fd, e.an, e.cath, e.dpn, e.fd);
            end
            total++;
            if ($countones(~an) > 1) begin
                bad++;
                $display("FAIL exclusive f%0d c%0d: got an=%b, want at most one low bit", fi, c, an);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(S1234, S1234, 32, 4'b0100, 4'b0000, 32, 32, C1234, 4'b0000, 4'b1111);
        tbl[1]  = mk(S1234, S0000, 12, 4'b0100, 4'b0000, 32, 32, C1234, 4'b0000, 4'b1111);
        tbl[2]  = mk(S0000, S0000, 32, 4'b0100, 4'b0000, 32, 32, C0000, 4'b0100, 4'b1111);
        tbl[3]  = mk(S1234, S1234, 32, 4'b0100, 4'b0000, 32, 32, C1234, 4'b0100, 4'b1111);
        tbl[4]  = mk(S1234, S1234, 32, 4'b0100, 4'b0001, 32, 32, C1234, 4'b0000, 4'b1110);
        tbl[5]  = mk(S1234, S1234, 32, 4'b0000, 4'b0001, 28, 32, C1234, 4'b0000, 4'b1110);
        tbl[6]  = mk(S1234, S1234, 32, 4'b0000, 4'b0001,  0, 12, C1234, 4'b0000, 4'b1110);
        tbl[7]  = mk(S1234, S1234, 32, 4'b0001, 4'b0001, 32, 32, C1234, 4'b0001, 4'b1110);
        tbl[8]  = mk(S1234, S1234, 32, 4'b0000, 4'b0000, 32, 32, C1234, 4'b0000, 4'b1111);
        tbl[9]  = mk(S1234, S1234, 32, 4'b1000, 4'b0000, 32, 32, C1234, 4'b0000, 4'b1111);
        tbl[10] = mk(S1234, S1234, 32, 4'b1000, 4'b0000, 32, 32, C1234, 4'b0000, 4'b1111);
        tbl[11] = mk(S1234, S1234, 32, 4'b1000, 4'b0000, 32, 32, C1234, 4'b1000, 4'b1111);

        resetn     = 1'b1;
        enable     = 1'b1;
        seg_in     = '0;
        blink_mask = '0;
        dp_mask    = '0;
        #1 resetn  = 1'b0;

        for (int i = 0; i < 5; i++) begin
            seg_in = 28'($urandom);
            step();
            check_reset($sformatf("reset_hold%0d", i));
        end
        resetn = 1'b1;

        for (int fi = 0; fi < 12; fi++) begin
            if (fi == 9) begin
                // Abort mid-slot 2 of frame 8; reset must act before the next edge.
                #3 resetn = 1'b0;
                #1 check_reset("reset_async");
                step();
                check_reset("reset_async_hold0");
                step();
                check_reset("reset_async_hold1");
                resetn = 1'b1;
            end
            run_frame(fi, (fi == 8) ? 19 : FRAME - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
